md_stall_ctrl: RTL and testbench

//  Multiply/divide sequencer and pipeline stall controller for the 5-stage MIPS core.
//  - Launches mult/multu/div/divu from the E stage and models the multi-cycle latency with a busy counter.
//  - Owns the HI/LO registers; feeds mfhi/mflo.
//  - Holds F/D and bubbles the D/E register while a D-stage MD-class instruction must wait.

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_decode.sv | 28 ++
 rtl/md_stall_ctrl.sv | 104 ++++++++++
 tb/tb_md_stall_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared opcode/funct encodings, latency defaults and MD operation enum
package md_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    typedef enum logic [3:0] {
        MD_NONE,
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MFHI,
        MD_MFLO,
        MD_MTHI,
        MD_MTLO
    } md_op;

endpackage

// File: rtl/md_decode.sv
// md_decode: classifies a 32-bit instruction into its MD operation (or MD_NONE)
module md_decode
    import md_pkg::*;
(
    input  logic [31:0] instr_i,
    output md_op        op_o
);

    logic [5:0] funct;
    logic       unused_bits;

    assign funct       = instr_i[5:0];
    assign unused_bits = ^instr_i[25:6];

    // Only SPECIAL-opcode instructions can be MD-class; the funct field picks the op.
    always_comb begin
        op_o = (instr_i[31:26] != OP_SPECIAL) ? MD_NONE  :
               (funct == FUNCT_MULT)          ? MD_MULT  :
               (funct == FUNCT_MULTU)         ? MD_MULTU :
               (funct == FUNCT_DIV)           ? MD_DIV   :
               (funct == FUNCT_DIVU)          ? MD_DIVU  :
               (funct == FUNCT_MFHI)          ? MD_MFHI  :
               (funct == FUNCT_MFLO)          ? MD_MFLO  :
               (funct == FUNCT_MTHI)          ? MD_MTHI  :
               (funct == FUNCT_MTLO)          ? MD_MTLO  : MD_NONE;
    end

endmodule

// File: rtl/md_stall_ctrl.sv
// md_stall_ctrl: mult/div sequencer with HI/LO ownership and D-stage MD hazard stall
module md_stall_ctrl #(
    parameter int MULT_CYC = md_pkg::MULT_CYC,
    parameter int DIV_CYC  = md_pkg::DIV_CYC,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] e_instr,
    input  logic [31:0] e_rs_val,
    input  logic [31:0] e_rt_val,
    input  logic [31:0] d_instr,
    output logic        busy,
    output logic        stall,
    output logic        en_pc,
    output logic        en_fd,
    output logic        clr_de,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    import md_pkg::*;

    md_op               e_op;
    md_op               d_op;
    logic               e_calc;
    logic               start;
    logic               div0;
    logic [31:0]        dv;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic [63:0]        result;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        pend_q, pend_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;

    md_decode u_dec_e (.instr_i(e_instr), .op_o(e_op));
    md_decode u_dec_d (.instr_i(d_instr), .op_o(d_op));

    assign busy   = (cnt_q != '0);
    assign e_calc = (e_op == MD_MULT) || (e_op == MD_MULTU) || (e_op == MD_DIV) || (e_op == MD_DIVU);
    assign start  = e_calc && !busy;
    assign stall  = (d_op != MD_NONE) && (busy || e_calc);
    assign en_pc  = ~stall;
    assign en_fd  = ~stall;
    assign clr_de = stall;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Result datapath; a zero divisor is replaced by 1 so the dividers stay defined, and the
    // pending value then re-commits the current HI/LO so they appear unchanged.
    always_comb begin
        div0   = (e_rt_val == '0);
        dv     = div0 ? 32'd1 : e_rt_val;
        prod_s = 64'($signed(e_rs_val)) * 64'($signed(e_rt_val));
        prod_u = {32'b0, e_rs_val} * {32'b0, e_rt_val};
        quo_s  = $signed(e_rs_val) / $signed(dv);
        rem_s  = $signed(e_rs_val) % $signed(dv);
        quo_u  = e_rs_val / dv;
        rem_u  = e_rs_val % dv;
        result = (e_op == MD_MULT)  ? prod_s          :
                 (e_op == MD_MULTU) ? prod_u          :
                 div0               ? {hi_q, lo_q}    :
                 (e_op == MD_DIV)   ? {rem_s, quo_s}  : {rem_u, quo_u};
    end

    // Next state: launch loads the counter and pending result, the last busy cycle commits HI/LO,
    // and mthi/mtlo write directly when the unit is idle.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (start) begin
            cnt_d  = ((e_op == MD_MULT) || (e_op == MD_MULTU)) ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
            pend_d = result;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) {hi_d, lo_d} = pend_q;
        end
        if (!busy && e_op == MD_MTHI) hi_d = e_rs_val;
        if (!busy && e_op == MD_MTLO) lo_d = e_rs_val;
    end

    // State registers; reset clears everything and overrides a coincident launch.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// tb_md_stall_ctrl: directed scoreboard bench for the MD sequencer and stall controller
module tb_md_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] e_instr, e_rs_val, e_rt_val, d_instr;
    logic        busy, stall, en_pc, en_fd, clr_de;
    logic [31:0] hi, lo;

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] sb[$];

    md_stall_ctrl dut (
        .clk(clk), .reset(reset), .e_instr(e_instr), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
        .d_instr(d_instr), .busy(busy), .stall(stall), .en_pc(en_pc), .en_fd(en_fd),
        .clr_de(clr_de), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {6'b0, 5'd1, 5'd2, 10'd0, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an MD op from E, then track busy/stall until it retires and check HI/LO.
    task automatic run_md(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [63:0] exp, input int n, input logic [31:0] d_ins,
                          input logic exp_stall);
        int cyc;
        int stl;
        logic [63:0] e;
        e_instr  = ins;
        e_rs_val = rs;
        e_rt_val = rt;
        d_instr  = d_ins;
        sb.push_back(exp);
        #1;
        chk("start_busy", 32'(busy), 32'(0));
        chk("start_stall", 32'(stall), 32'(exp_stall));
        chk("start_clr_de", 32'(clr_de), 32'(exp_stall));
        stl = stall ? 1 : 0;
        tick();
        e_instr = 32'h0;
        #1;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (stall) stl++;
            chk("busy_stall", 32'(stall), 32'(exp_stall));
            chk("busy_en_pc", 32'(en_pc), 32'(!exp_stall));
            tick();
        end
        chk("busy_cycles", 32'(cyc), 32'(n));
        chk("stall_cycles", 32'(stl), exp_stall ? 32'(n + 1) : 32'(0));
        chk("idle_stall", 32'(stall), 32'(0));
        e = sb.pop_front();
        chk("hi", hi, e[63:32]);
        chk("lo", lo, e[31:0]);
    endtask

    localparam logic [5:0] F_MULT = 6'b011000, F_DIV = 6'b011010, F_DIVU = 6'b011011;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;
    localparam logic [5:0] F_MTHI = 6'b010001, F_MTLO = 6'b010011, F_ADDU = 6'b100001;

    initial begin
        reset    = 1'b1;
        e_instr  = rtype(F_MULT);
        e_rs_val = 32'd3;
        e_rt_val = 32'd4;
        d_instr  = 32'h0;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        e_instr = 32'h0;
        reset   = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'(0));

        run_md(rtype(F_MULT), 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB}, 5, 32'h0, 1'b0);

        run_md(rtype(F_DIVU), 32'd100, 32'd7, {32'd2, 32'd14}, 10, rtype(F_MFLO), 1'b1);
        e_instr = rtype(F_MFLO);
        d_instr = 32'h0;
        #1;
        chk("mflo_lo", lo, 32'd14);
        chk("mflo_stall", 32'(stall), 32'(0));
        tick();

        run_md(rtype(F_DIV), 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, 32'h0, 1'b0);

        e_instr = rtype(F_MTHI); e_rs_val = 32'd5;
        tick();
        e_instr = rtype(F_MTLO); e_rs_val = 32'd6;
        tick();
        chk("mt_hi", hi, 32'd5);
        chk("mt_lo", lo, 32'd6);
        run_md(rtype(F_DIV), 32'd9, 32'd0, {32'd5, 32'd6}, 10, rtype(F_ADDU), 1'b0);

        e_instr = rtype(F_MTHI); e_rs_val = 32'hDEADBEEF; d_instr = 32'h0;
        #1;
        chk("mthi_stall", 32'(stall), 32'(0));
        tick();
        e_instr = 32'h0;
        chk("mthi_hi", hi, 32'hDEADBEEF);
        chk("mthi_lo", lo, 32'd6);

        run_md(rtype(F_MULT), 32'd6, 32'd7, {32'd0, 32'd42}, 5, rtype(F_MULT), 1'b1);
        run_md(rtype(F_MULT), 32'h00010000, 32'hFFFF0000, {32'hFFFFFFFF, 32'h0}, 5, 32'h0, 1'b0);

        e_instr = rtype(F_DIVU); e_rs_val = 32'd100; e_rt_val = 32'd7; d_instr = rtype(F_MFHI);
        tick();
        e_instr = 32'h0;
        for (int i = 0; i < 7; i++) tick();
        chk("pre_reset_busy", 32'(busy), 32'(1));
        chk("pre_reset_stall", 32'(stall), 32'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset_busy", 32'(busy), 32'(0));
        chk("post_reset_hi", hi, 32'h0);
        chk("post_reset_lo", lo, 32'h0);
        chk("post_reset_stall", 32'(stall), 32'(0));
        for (int i = 0; i < 4; i++) tick();
        chk("late_busy", 32'(busy), 32'(0));
        chk("late_hi", hi, 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
